// File: rtl/ps2_keyboard_hack_if.sv
// rtl/ps2_keyboard_hack_if.sv - PS/2 line inputs and Hack keyboard word outputs
interface ps2_keyboard_hack_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] key_code;
    logic        key_strobe;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key_code,
        input  key_strobe,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key_code,
        output key_strobe,
        output frame_err
    );
endinterface

// File: rtl/ps2_keyboard_hack.sv
// rtl/ps2_keyboard_hack.sv - PS/2 Set-2 receiver and decoder producing the Hack keyboard word
module ps2_keyboard_hack #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ps2_keyboard_hack_if.slave   kb
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic [FW-1:0] clk_cnt, data_cnt;
    logic          clk_f, data_f, clk_f_q;
    logic          fall;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_byte;
    logic          parity_ok;
    logic [TW-1:0] timer;
    logic          timeout, deliver, err_now;

    logic          ext, brk, shift;
    logic [15:0]   key_code_q;
    logic          key_strobe_q, frame_err_q;
    logic [15:0]   lut_code;

    // Lines idle high, so synchronisers and filters reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_cnt   <= '0;
            data_cnt  <= '0;
            clk_f     <= 1'b1;
            data_f    <= 1'b1;
            clk_f_q   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], kb.ps2_clk};
            data_sync <= {data_sync[0], kb.ps2_data};
            clk_f_q   <= clk_f;
            if (clk_sync[1] != clk_f) begin
                if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_f   <= clk_sync[1];
                    clk_cnt <= '0;
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end else begin
                clk_cnt <= '0;
            end
            if (data_sync[1] != data_f) begin
                if (data_cnt == FW'(FILTER_LEN - 1)) begin
                    data_f   <= data_sync[1];
                    data_cnt <= '0;
                end else begin
                    data_cnt <= data_cnt + 1'b1;
                end
            end else begin
                data_cnt <= '0;
            end
        end
    end

    assign fall    = clk_f_q & ~clk_f;
    assign timeout = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_f) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        deliver = fall && (state == STOP) && parity_ok && data_f;
        err_now = timeout
               || (fall && (state == IDLE) && data_f)
               || (fall && (state == STOP) && !(parity_ok && data_f));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            bit_cnt     <= '0;
            rx_byte     <= '0;
            parity_ok   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err_now;
            if (state == IDLE || fall) timer <= '0;
            else                       timer <= timer + 1'b1;
            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        rx_byte <= {data_f, rx_byte[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  parity_ok <= ^{rx_byte, data_f};
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [15:0] lookup(input logic e, input logic [7:0] b, input logic sh);
        logic [15:0] c;
        c = '0;
        if (e) begin
            case (b)
                8'h6B: c = 16'd130;  8'h75: c = 16'd131;
                8'h74: c = 16'd132;  8'h72: c = 16'd133;
                8'h6C: c = 16'd134;  8'h69: c = 16'd135;
                8'h7D: c = 16'd136;  8'h7A: c = 16'd137;
                8'h70: c = 16'd138;  8'h71: c = 16'd139;
                default: c = '0;
            endcase
        end else begin
            case (b)
                8'h1C: c = 16'd97;   8'h32: c = 16'd98;   8'h21: c = 16'd99;
                8'h23: c = 16'd100;  8'h24: c = 16'd101;  8'h2B: c = 16'd102;
                8'h34: c = 16'd103;  8'h33: c = 16'd104;  8'h43: c = 16'd105;
                8'h3B: c = 16'd106;  8'h42: c = 16'd107;  8'h4B: c = 16'd108;
                8'h3A: c = 16'd109;  8'h31: c = 16'd110;  8'h44: c = 16'd111;
                8'h4D: c = 16'd112;  8'h15: c = 16'd113;  8'h2D: c = 16'd114;
                8'h1B: c = 16'd115;  8'h2C: c = 16'd116;  8'h3C: c = 16'd117;
                8'h2A: c = 16'd118;  8'h1D: c = 16'd119;  8'h22: c = 16'd120;
                8'h35: c = 16'd121;  8'h1A: c = 16'd122;
                8'h45: c = 16'd48;   8'h16: c = 16'd49;   8'h1E: c = 16'd50;
                8'h26: c = 16'd51;   8'h25: c = 16'd52;   8'h2E: c = 16'd53;
                8'h36: c = 16'd54;   8'h3D: c = 16'd55;   8'h3E: c = 16'd56;
                8'h46: c = 16'd57;   8'h29: c = 16'd32;
                8'h5A: c = 16'd128;  8'h66: c = 16'd129;  8'h76: c = 16'd140;
                8'h05: c = 16'd141;  8'h06: c = 16'd142;  8'h04: c = 16'd143;
                8'h0C: c = 16'd144;  8'h03: c = 16'd145;  8'h0B: c = 16'd146;
                8'h83: c = 16'd147;  8'h0A: c = 16'd148;  8'h01: c = 16'd149;
                8'h09: c = 16'd150;  8'h78: c = 16'd151;  8'h07: c = 16'd152;
                default: c = '0;
            endcase
            // Only letters take the shifted (upper-case) form
            if (sh && c >= 16'd97 && c <= 16'd122) c = c - 16'd32;
        end
        return c;
    endfunction

    assign lut_code = lookup(ext, rx_byte, shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext          <= 1'b0;
            brk          <= 1'b0;
            shift        <= 1'b0;
            key_code_q   <= '0;
            key_strobe_q <= 1'b0;
        end else begin
            key_strobe_q <= 1'b0;
            if (deliver) begin
                if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) begin
                        shift <= ~brk;
                    end else if (lut_code != '0) begin
                        // A break only clears the word if it releases the latest key
                        if (brk) begin
                            if (lut_code == key_code_q) begin
                                key_code_q   <= '0;
                                key_strobe_q <= 1'b1;
                            end
                        end else if (lut_code != key_code_q) begin
                            key_code_q   <= lut_code;
                            key_strobe_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign kb.key_code   = key_code_q;
    assign kb.key_strobe = key_strobe_q;
    assign kb.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_hack.sv
// tb/tb_ps2_keyboard_hack.sv - scoreboard bench for the PS/2 Hack keyboard front end
module tb_ps2_keyboard_hack;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [16:0] exp_q[$];

    ps2_keyboard_hack_if kb();

    ps2_keyboard_hack #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kb    (kb)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe or error pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && (kb.key_strobe || kb.frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output strobe=%0b err=%0b code=%0d", kb.key_strobe, kb.frame_err, kb.key_code);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (e[16]) begin
                    if (!kb.frame_err || kb.key_strobe) begin
                        errors++;
                        $display("FAIL frame_err got strobe=%0b err=%0b want err=1", kb.key_strobe, kb.frame_err);
                    end
                end else if (!kb.key_strobe || kb.frame_err || kb.key_code != e[15:0]) begin
                    errors++;
                    $display("FAIL key_strobe got code=%0d strobe=%0b err=%0b want code=%0d", kb.key_code, kb.key_strobe, kb.frame_err, e[15:0]);
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        kb.ps2_data = b;
        repeat (10) @(posedge clk);
        kb.ps2_clk = 1'b0;
        repeat (20) @(posedge clk);
        kb.ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] v, input logic bad);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(v[i]);
        ps2_bit((~^v) ^ bad);
        ps2_bit(1'b1);
        kb.ps2_data = 1'b1;
    endtask

    task automatic exp_code(input logic [15:0] c);
        exp_q.push_back({1'b0, c});
    endtask

    task automatic exp_err();
        exp_q.push_back({1'b1, 16'd0});
    endtask

    task automatic check_code(input string name, input logic [15:0] want);
        @(negedge clk);
        checks++;
        if (kb.key_code !== want) begin
            errors++;
            $display("FAIL %s key_code got %0d want %0d", name, kb.key_code, want);
        end
    endtask

    initial begin
        kb.ps2_clk  = 1'b1;
        kb.ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (kb.key_code !== 16'd0 || kb.key_strobe !== 1'b0 || kb.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset got code=%0d strobe=%0b err=%0b want 0/0/0", kb.key_code, kb.key_strobe, kb.frame_err);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check_code("after_reset", 16'd0);

        // A make and break
        exp_code(16'd97); send(8'h1C, 1'b0);
        check_code("a_make", 16'd97);
        send(8'hF0, 1'b0); exp_code(16'd0); send(8'h1C, 1'b0);
        check_code("a_break", 16'd0);

        // Shifted A, shift bytes themselves silent
        send(8'h12, 1'b0);
        exp_code(16'd65); send(8'h1C, 1'b0);
        check_code("shift_a", 16'd65);
        send(8'hF0, 1'b0); exp_code(16'd0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        check_code("shift_a_break", 16'd0);

        // Extended up arrow, then bare 0x75 is unmapped
        send(8'hE0, 1'b0); exp_code(16'd131); send(8'h75, 1'b0);
        check_code("up_make", 16'd131);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); exp_code(16'd0); send(8'h75, 1'b0);
        send(8'h75, 1'b0);
        check_code("bare_75", 16'd0);

        // Bad parity then recovery
        exp_err(); send(8'h1C, 1'b1);
        check_code("bad_parity", 16'd0);
        exp_code(16'd97); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); exp_code(16'd0); send(8'h1C, 1'b0);

        // Timeout after 4 data bits
        exp_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        kb.ps2_data = 1'b1;
        repeat (TMO + 60) @(posedge clk);
        check_code("timeout", 16'd0);
        exp_code(16'd97); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); exp_code(16'd0); send(8'h1C, 1'b0);

        // Rollover, typematic repeat, non-latest release, clock glitch
        exp_code(16'd97); send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        exp_code(16'd98); send(8'h32, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        check_code("rollover", 16'd98);
        @(posedge clk); kb.ps2_clk = 1'b0;
        @(posedge clk); kb.ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        check_code("glitch", 16'd98);
        send(8'hF0, 1'b0); exp_code(16'd0); send(8'h32, 1'b0);

        // Digits ignore shift; F12 and extended delete
        send(8'h12, 1'b0);
        exp_code(16'd49); send(8'h16, 1'b0);
        send(8'hF0, 1'b0); exp_code(16'd0); send(8'h16, 1'b0);
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        exp_code(16'd152); send(8'h07, 1'b0);
        send(8'hE0, 1'b0); exp_code(16'd139); send(8'h71, 1'b0);
        check_code("ext_del", 16'd139);

        // Start bit of 1
        exp_err(); ps2_bit(1'b1);
        check_code("start_err", 16'd139);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
